dispensador_ctrl: RTL and testbench
===================================

# dispensador_ctrl

Downstream stage of the vending machine top level: consumes the product code, the `listo` strobe and the change count produced by the sale FSM, and converts them into timed physical actuation. It drives one motor line per product for a fixed time, then ejects the change one coin at a time with fixed pulse and gap widths, and reports busy/done status. Requests that arrive while a delivery is in progress are dropped and flagged.

## Interface
- `T_MOTOR`, default 50: motor-on duration in clk cycles (≥1).
- `T_PULSO`, default 10: coin-eject pulse width in cycles (≥1).
- `T_PAUSA`, default 5: gap between consecutive eject pulses in cycles (≥1).
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `producto`  in  2  product code 0–3, valid with `listo`.
- `listo`  in  1  sale-complete strobe from the sale FSM; rising-edge detected internally.
- `cambio`  in  2  number of coins to return (0–3), valid with `listo`.
- `motor`  out  4  one-hot motor enable; bit n drives product n.
- `expulsar`  out  1  coin-eject solenoid; one high pulse per returned coin.
- `ocupado`  out  1  high while a delivery is in progress.
- `entregado`  out  1  one-cycle pulse when a delivery finishes.
- `perdido`  out  1  one-cycle pulse when a request is rejected because the block is busy.

## Operation
- All outputs are registered. Reset value of every output is 0; the state is REPOSO; the internal `listo_q` is 0; the counters are 0.
- Accept event: `listo`=1 while `listo_q`=0, with state REPOSO. The block latches `producto` and `cambio` into internal registers in the same edge. Inputs are ignored at all other times.
- States:
  - REPOSO: idle with all outputs 0. An accept event moves the state to MOTOR.
  - MOTOR: `motor[prod_reg]`=1 for exactly T_MOTOR cycles. When the count is done, the state goes to PULSO if `cambio_reg`≠0, else to FIN.
  - PULSO: `expulsar`=1 for exactly T_PULSO cycles. At the end, the remaining-coin count decrements. The state goes to FIN if the count is now 0, else to PAUSA.
  - PAUSA: all actuators 0 for T_PAUSA cycles, then back to PULSO.
  - FIN: `entregado`=1 for one cycle, then REPOSO.
- `ocupado`=1 in MOTOR, PULSO, PAUSA and FIN.
- `perdido`: asserts for one cycle on a `listo` rising edge while the state is not REPOSO. The ongoing delivery and the latched registers are unaffected.
- `listo` held high after acceptance does not re-trigger. A new rising edge is required.
- Duration counter width is clog2(max(T_MOTOR,T_PULSO,T_PAUSA)+1). The coin counter is 2 bits and never wraps: it is only decremented when non-zero.
- `motor` is at most one-hot. `motor` and `expulsar` are never high in the same cycle.
- Reset assertion at any point: outputs clear immediately (asynchronously), the state returns to REPOSO, and any pending coins are discarded.

## Timing
- Accept edge at cycle k: `ocupado` and `motor` rise at k+1, and `motor` is high for cycles k+1 … k+T_MOTOR.
- With c coins, the first `expulsar` starts at k+T_MOTOR+1. Pulses and gaps alternate with no extra idle cycles.
- `entregado` fires at cycle k + T_MOTOR + c·T_PULSO + max(c−1,0)·T_PAUSA + 1. `ocupado` falls the cycle after that.
- The earliest next acceptance is the first cycle back in REPOSO. A rising edge of `listo` seen during FIN is `perdido`.
- `perdido` is asserted the cycle after the offending edge.

## Test plan
Bench parameters: T_MOTOR=4, T_PULSO=2, T_PAUSA=1.
- **Reset.** Hold `rst`=0 for 3 cycles with random inputs -> all outputs 0. Release, keep `listo`=0 for 10 cycles -> outputs stay 0.
- **No change.** Pulse `listo` with `producto`=2, `cambio`=0 -> `motor`=4'b0100 for 4 cycles, `expulsar` never high, `entregado` one cycle at k+5, `ocupado` high for 5 cycles.
- **Three coins.** `producto`=1, `cambio`=3 -> `motor`=4'b0010 for 4 cycles, then `expulsar` pattern 1,1,0,1,1,0,1,1 with exactly 3 rising edges, then `entregado` at k+13.
- **Busy request.** During MOTOR, pulse `listo` with `producto`=3, `cambio`=2 -> `perdido` one cycle, motor stays on bit 1, original change count is delivered. `listo` held high from acceptance through FIN -> no second delivery and no `perdido`.
- **Reset mid-eject.** Assert `rst`=0 during the second PULSO -> `expulsar`, `ocupado` and `motor` drop without waiting for a clock edge. After release, a new request with `producto`=0, `cambio`=1 completes normally with one pulse.
- **Back-to-back.** Issue a second `listo` edge the first cycle after `ocupado` falls -> accepted, with `motor` rising one cycle later and no `perdido`.

Source files
------------

// File: rtl/dispensador_ctrl.sv
// dispensador_ctrl: turns an accepted sale (product, change count) into a
// timed motor run followed by one eject pulse per returned coin.
//
// state  | meaning
// -------+---------------------------------------------------------------
// REPOSO | idle, waiting for a rising edge of listo
// MOTOR  | motor[prod_reg] on, duration timer running
// PULSO  | expulsar on for one coin, duration timer running
// PAUSA  | gap between coin pulses, all actuators off
// FIN    | one-cycle entregado, then back to REPOSO
module dispensador_ctrl #(
    parameter int T_MOTOR = 50,
    parameter int T_PULSO = 10,
    parameter int T_PAUSA = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] producto,
    input  logic       listo,
    input  logic [1:0] cambio,
    output logic [3:0] motor,
    output logic       expulsar,
    output logic       ocupado,
    output logic       entregado,
    output logic       perdido
);

    localparam int T_MAX = (T_MOTOR > T_PULSO)
                         ? ((T_MOTOR > T_PAUSA) ? T_MOTOR : T_PAUSA)
                         : ((T_PULSO > T_PAUSA) ? T_PULSO : T_PAUSA);
    localparam int CW = $clog2(T_MAX + 1);

    // Timers count down from T-1 to 0 so a phase lasts exactly T cycles.
    localparam logic [CW-1:0] LD_MOTOR = CW'(T_MOTOR - 1);
    localparam logic [CW-1:0] LD_PULSO = CW'(T_PULSO - 1);
    localparam logic [CW-1:0] LD_PAUSA = CW'(T_PAUSA - 1);

    typedef enum logic [2:0] {
        REPOSO = 3'd0,
        MOTOR  = 3'd1,
        PULSO  = 3'd2,
        PAUSA  = 3'd3,
        FIN    = 3'd4
    } estado_t;

    estado_t       state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    prod_reg, prod_d;
    logic [1:0]    cambio_reg, cambio_d;
    logic          listo_q;
    logic          rise;
    logic [3:0]    motor_d;
    logic          expulsar_d;
    logic          ocupado_d;
    logic          entregado_d;
    logic          perdido_d;

    // State, timers, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= REPOSO;
            cnt        <= '0;
            prod_reg   <= 2'd0;
            cambio_reg <= 2'd0;
            listo_q    <= 1'b0;
            motor      <= 4'd0;
            expulsar   <= 1'b0;
            ocupado    <= 1'b0;
            entregado  <= 1'b0;
            perdido    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            prod_reg   <= prod_d;
            cambio_reg <= cambio_d;
            listo_q    <= listo;
            motor      <= motor_d;
            expulsar   <= expulsar_d;
            ocupado    <= ocupado_d;
            entregado  <= entregado_d;
            perdido    <= perdido_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so that
    // they are registered yet line up with the state they belong to.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        prod_d   = prod_reg;
        cambio_d = cambio_reg;
        rise     = listo && !listo_q;

        case (state)
            REPOSO: begin
                if (rise) begin
                    state_d  = MOTOR;
                    cnt_d    = LD_MOTOR;
                    prod_d   = producto;
                    cambio_d = cambio;
                end
            end
            MOTOR: begin
                if (cnt == '0) begin
                    if (cambio_reg != 2'd0) begin
                        state_d = PULSO;
                        cnt_d   = LD_PULSO;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            PULSO: begin
                if (cnt == '0) begin
                    // Coin count only moves when non-zero, so it cannot wrap.
                    if (cambio_reg != 2'd0) begin
                        cambio_d = cambio_reg - 2'd1;
                    end
                    if (cambio_reg <= 2'd1) begin
                        state_d = FIN;
                    end else begin
                        state_d = PAUSA;
                        cnt_d   = LD_PAUSA;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            PAUSA: begin
                if (cnt == '0) begin
                    state_d = PULSO;
                    cnt_d   = LD_PULSO;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            FIN: begin
                state_d = REPOSO;
                cnt_d   = '0;
            end
            default: begin
                state_d = REPOSO;
                cnt_d   = '0;
            end
        endcase

        motor_d     = (state_d == MOTOR) ? (4'b0001 << prod_d) : 4'b0000;
        expulsar_d  = (state_d == PULSO);
        ocupado_d   = (state_d != REPOSO);
        entregado_d = (state_d == FIN);
        // A new edge while a delivery runs (FIN included) is dropped.
        perdido_d   = rise && (state != REPOSO);
    end

endmodule

// File: tb/tb_dispensador_ctrl.sv
// Bench for dispensador_ctrl: the expected output vector of every cycle is
// queued when a request is driven and compared as the DUT produces it.
module tb_dispensador_ctrl;

    localparam int TM = 4;
    localparam int TP = 2;
    localparam int TG = 1;

    logic       clk;
    logic       rst;
    logic [1:0] producto;
    logic       listo;
    logic [1:0] cambio;
    logic [3:0] motor;
    logic       expulsar;
    logic       ocupado;
    logic       entregado;
    logic       perdido;

    int n_chk = 0;
    int n_err = 0;
    int ncyc  = 0;
    logic listo_prev = 1'b0;

    // {motor[3:0], expulsar, ocupado, entregado, perdido}
    logic [7:0] exp_q[$];

    dispensador_ctrl #(
        .T_MOTOR(TM),
        .T_PULSO(TP),
        .T_PAUSA(TG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .producto (producto),
        .listo    (listo),
        .cambio   (cambio),
        .motor    (motor),
        .expulsar (expulsar),
        .ocupado  (ocupado),
        .entregado(entregado),
        .perdido  (perdido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {motor, expulsar, ocupado, entregado, perdido};
    endfunction

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s actual=%b expected=%b", tag, act, expv);
        end
    endtask

    // Expected cycles of one delivery, starting the cycle after acceptance.
    task automatic plan(input logic [1:0] p, input logic [1:0] c);
        logic [3:0] oh;
        oh = 4'b0001 << p;
        for (int i = 0; i < TM; i++) exp_q.push_back({oh, 4'b0100});
        for (int j = 0; j < int'(c); j++) begin
            for (int i = 0; i < TP; i++) exp_q.push_back({4'b0000, 4'b1100});
            if (j < int'(c) - 1)
                for (int i = 0; i < TG; i++) exp_q.push_back({4'b0000, 4'b0100});
        end
        exp_q.push_back({4'b0000, 4'b0110});
    endtask

    // One cycle: compare the outputs of the cycle just ending, then drive.
    task automatic tick(input logic l, input logic [1:0] p, input logic [1:0] c);
        logic [7:0] e;
        logic busy;
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        chk($sformatf("cyc%0d", ncyc), obs(), e);
        busy     = e[2];
        producto = p;
        cambio   = c;
        listo    = l;
        if (l && !listo_prev) begin
            if (!busy) plan(p, c);
            else if (exp_q.size() == 0) exp_q.push_back(8'h01);
            else exp_q[0] = exp_q[0] | 8'h01;
        end
        listo_prev = l;
        ncyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 2'd0);
    endtask

    initial begin
        rst = 1'b0; listo = 1'b0; producto = 2'd0; cambio = 2'd0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_hold%0d", i), obs(), 8'h00);
            producto = 2'($urandom_range(0, 3));
            cambio   = 2'($urandom_range(0, 3));
            listo    = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        listo = 1'b0; listo_prev = 1'b0;
        rst = 1'b1;
        idle(10);

        // No change, product 2
        tick(1'b1, 2'd2, 2'd0);
        idle(8);

        // Three coins, product 1
        tick(1'b1, 2'd1, 2'd3);
        idle(16);

        // Busy request during MOTOR
        tick(1'b1, 2'd1, 2'd2);
        tick(1'b0, 2'd0, 2'd0);
        tick(1'b1, 2'd3, 2'd2);
        idle(14);

        // listo held high through the whole delivery
        tick(1'b1, 2'd2, 2'd1);
        for (int i = 0; i < 9; i++) tick(1'b1, 2'd3, 2'd3);
        idle(4);

        // Reset during the second eject pulse
        tick(1'b1, 2'd3, 2'd2);
        idle(8);
        #2 rst = 1'b0;
        #1 chk("rst_async", obs(), 8'h00);
        exp_q.delete();
        listo = 1'b0; listo_prev = 1'b0;
        @(negedge clk);
        chk("rst_mid_hold", obs(), 8'h00);
        rst = 1'b1;
        tick(1'b1, 2'd0, 2'd1);
        idle(10);

        // Edge seen during FIN is dropped
        tick(1'b1, 2'd1, 2'd0);
        tick(1'b0, 2'd0, 2'd0);
        idle(3);
        tick(1'b1, 2'd2, 2'd2);
        idle(3);

        // Back-to-back: edge on the first idle cycle after ocupado falls
        tick(1'b1, 2'd2, 2'd0);
        tick(1'b0, 2'd0, 2'd0);
        idle(4);
        tick(1'b1, 2'd3, 2'd1);
        tick(1'b0, 2'd0, 2'd0);
        idle(12);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
